// File: rtl/port_iq_detector.sv
// Port I/Q detector: integrates N = 2^LOG2N samples taken at 4x the stimulus
// frequency into signed in-phase/quadrature sums. Optional magnitude output via `PORT_IQ_DETECTOR_MAG_EN.
module port_iq_detector #(
  parameter int DW    = 16,
  parameter int LOG2N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DW-1:0]         s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DW+LOG2N-1:0]   m_i,
  output logic [DW+LOG2N-1:0]   m_q,
`ifdef PORT_IQ_DETECTOR_MAG_EN
  output logic [DW+LOG2N-1:0]   m_mag,
`endif
  output logic                  busy
);

  localparam int W = DW + LOG2N;

`ifdef PORT_IQ_DETECTOR_MAG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, MAG = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t             state_q;
  logic [W-1:0]       acc_i_q, acc_q_q, acc_i_d, acc_q_d;
  logic [W-1:0]       ext_s;
  logic [1:0]         phase_q;
  logic [LOG2N-1:0]   cnt_q;
  logic               s_ready_q, m_valid_q, busy_q;
  logic               accept_s;

  assign accept_s = s_valid & s_ready_q;
  assign ext_s    = {{LOG2N{s_data[DW-1]}}, s_data};

  // Phase-selected accumulate: 0:+I, 1:+Q, 2:-I, 3:-Q
  always_comb begin
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    case (phase_q)
      2'd0:    acc_i_d = acc_i_q + ext_s;
      2'd1:    acc_q_d = acc_q_q + ext_s;
      2'd2:    acc_i_d = acc_i_q - ext_s;
      2'd3:    acc_q_d = acc_q_q - ext_s;
      default: begin
        acc_i_d = acc_i_q;
        acc_q_d = acc_q_q;
      end
    endcase
  end

`ifdef PORT_IQ_DETECTOR_MAG_EN
  logic [W-1:0] abs_i_s, abs_q_s, max_s, min_s, mag_d, mag_q;
  logic [W:0]   mag_sum_s;

  // Alpha-max-plus-beta-min estimate, saturating to the output width
  always_comb begin
    abs_i_s = acc_i_q[W-1] ? (~acc_i_q + {{(W-1){1'b0}}, 1'b1}) : acc_i_q;
    abs_q_s = acc_q_q[W-1] ? (~acc_q_q + {{(W-1){1'b0}}, 1'b1}) : acc_q_q;
    if (abs_i_s >= abs_q_s) begin
      max_s = abs_i_s;
      min_s = abs_q_s;
    end else begin
      max_s = abs_q_s;
      min_s = abs_i_s;
    end
    mag_sum_s = {1'b0, max_s} + {2'b00, min_s[W-1:1]};
    if (mag_sum_s[W]) begin
      mag_d = {W{1'b1}};
    end else begin
      mag_d = mag_sum_s[W-1:0];
    end
  end

  assign m_mag = mag_q;
`endif

  // Control FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_i_q   <= {W{1'b0}};
      acc_q_q   <= {W{1'b0}};
      phase_q   <= 2'd0;
      cnt_q     <= {LOG2N{1'b0}};
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PORT_IQ_DETECTOR_MAG_EN
      mag_q     <= {W{1'b0}};
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_i_q   <= {W{1'b0}};
            acc_q_q   <= {W{1'b0}};
            phase_q   <= 2'd0;
            cnt_q     <= {LOG2N{1'b0}};
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ACCUM;
          end else begin
            state_q   <= IDLE;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            phase_q <= phase_q + 2'd1;
            cnt_q   <= cnt_q + {{(LOG2N-1){1'b0}}, 1'b1};
            if (&cnt_q) begin
              s_ready_q <= 1'b0;
`ifdef PORT_IQ_DETECTOR_MAG_EN
              state_q   <= MAG;
`else
              m_valid_q <= 1'b1;
              state_q   <= DONE;
`endif
            end else begin
              state_q <= ACCUM;
            end
          end else begin
            state_q <= ACCUM;
          end
        end
`ifdef PORT_IQ_DETECTOR_MAG_EN
        MAG: begin
          mag_q     <= mag_d;
          m_valid_q <= 1'b1;
          state_q   <= DONE;
        end
`endif
        DONE: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            state_q   <= DONE;
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign busy    = busy_q;
  assign m_i     = acc_i_q;
  assign m_q     = acc_q_q;

endmodule

// File: tb/tb_port_iq_detector.sv
// Bench for port_iq_detector: one LOG2N=2 and one LOG2N=8 instance share the
// sample/handshake lines; a scoreboard queue holds the model's expected results.
module tb_port_iq_detector;

  localparam int W2 = 18;
  localparam int W8 = 24;
`ifdef PORT_IQ_DETECTOR_MAG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    longint i;
    longint q;
    longint mag;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start2, start8, s_valid, m_ready;
  logic [15:0] s_data;
  logic s_ready2, s_ready8, m_valid2, m_valid8, busy2, busy8;
  logic [W2-1:0] m_i2, m_q2, m_mag2;
  logic [W8-1:0] m_i8, m_q8, m_mag8;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t last_e;
  int samples[$];
  logic sel = 1'b0;
  logic cur_s_ready, cur_m_valid, cur_busy;
  longint cur_mi, cur_mq, cur_mag;

  always #5 clk = ~clk;

  port_iq_detector #(.DW(16), .LOG2N(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready2), .m_valid(m_valid2), .m_ready(m_ready),
    .m_i(m_i2), .m_q(m_q2),
`ifdef PORT_IQ_DETECTOR_MAG_EN
    .m_mag(m_mag2),
`endif
    .busy(busy2)
  );

  port_iq_detector #(.DW(16), .LOG2N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready8), .m_valid(m_valid8), .m_ready(m_ready),
    .m_i(m_i8), .m_q(m_q8),
`ifdef PORT_IQ_DETECTOR_MAG_EN
    .m_mag(m_mag8),
`endif
    .busy(busy8)
  );

`ifndef PORT_IQ_DETECTOR_MAG_EN
  assign m_mag2 = '0;
  assign m_mag8 = '0;
`endif

  always_comb begin
    cur_s_ready = sel ? s_ready8 : s_ready2;
    cur_m_valid = sel ? m_valid8 : m_valid2;
    cur_busy    = sel ? busy8 : busy2;
    cur_mi      = sel ? longint'($signed(m_i8)) : longint'($signed(m_i2));
    cur_mq      = sel ? longint'($signed(m_q8)) : longint'($signed(m_q2));
    cur_mag     = sel ? longint'(m_mag8) : longint'(m_mag2);
  end

  function automatic longint mag_model(input longint i, input longint q, input int w);
    longint a, b, mx, mn, r, sat;
    a = (i < 0) ? -i : i;
    b = (q < 0) ? -q : q;
    mx = (a >= b) ? a : b;
    mn = (a >= b) ? b : a;
    r = mx + mn / 2;
    sat = (longint'(1) << w) - 1;
    return (r > sat) ? sat : r;
  endfunction

  task automatic select(input logic s);
    sel = s;
    #1;
  endtask

  // Start one integration and feed nacc samples; pushes the model result when complete
  task automatic run_accum(input logic s, input int nacc, input bit rnd);
    longint ei = 0;
    longint eq = 0;
    int idx = 0;
    int guard = 0;
    int n;
    exp_t e;
    select(s);
    n = s ? 256 : 4;
    if (s) start8 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    start2 = 1'b0;
    while (idx < nacc && guard < 5000) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = s_valid ? 16'(samples[idx]) : 16'($urandom);
      if (s_valid && cur_s_ready) begin
        case (idx % 4)
          0: ei = ei + samples[idx];
          1: eq = eq + samples[idx];
          2: ei = ei - samples[idx];
          default: eq = eq - samples[idx];
        endcase
        idx++;
        if (idx == n) begin
          e.i = ei;
          e.q = eq;
          e.mag = mag_model(ei, eq, s ? W8 : W2);
          sb.push_back(e);
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    checks++;
    if (guard >= 5000) begin
      failures++;
      $display("FAIL accept_timeout: accepted %0d required %0d", idx, nacc);
    end
  endtask

  // Wait for m_valid, check latency and pop/compare the scoreboard
  task automatic wait_result();
    int cyc = 1;
    while (!cur_m_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== LAT) begin
      failures++;
      $display("FAIL latency: got %0d required %0d", cyc, LAT);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: got 0 entries required 1");
    end else begin
      last_e = sb.pop_front();
      if (cur_mi !== last_e.i) begin
        failures++;
        $display("FAIL m_i: got %0d required %0d", cur_mi, last_e.i);
      end
      checks++;
      if (cur_mq !== last_e.q) begin
        failures++;
        $display("FAIL m_q: got %0d required %0d", cur_mq, last_e.q);
      end
`ifdef PORT_IQ_DETECTOR_MAG_EN
      checks++;
      if (cur_mag !== last_e.mag) begin
        failures++;
        $display("FAIL m_mag: got %0d required %0d", cur_mag, last_e.mag);
      end
`endif
    end
  endtask

  task automatic finish_hs();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    checks++;
    if (cur_m_valid !== 1'b0 || cur_busy !== 1'b0) begin
      failures++;
      $display("FAIL handshake_idle: got valid=%0b busy=%0b required 0 0", cur_m_valid, cur_busy);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      select(k[0]);
      checks++;
      if (cur_busy !== 1'b0 || cur_m_valid !== 1'b0 || cur_s_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_flags dut%0d: got busy=%0b valid=%0b ready=%0b required 0 0 0",
                 tag, k, cur_busy, cur_m_valid, cur_s_ready);
      end
      checks++;
      if (cur_mi !== 64'sd0 || cur_mq !== 64'sd0 || cur_mag !== 64'sd0) begin
        failures++;
        $display("FAIL %s_sums dut%0d: got i=%0d q=%0d mag=%0d required 0 0 0",
                 tag, k, cur_mi, cur_mq, cur_mag);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_idle_zero("reset");
  endtask

  task automatic test_basic();
    samples = '{100, 200, -100, -200};
    run_accum(1'b0, 4, 1'b0);
    wait_result();
    checks++;
    if (last_e.i !== 64'sd200 || last_e.q !== 64'sd400) begin
      failures++;
      $display("FAIL basic_model: got %0d %0d required 200 400", last_e.i, last_e.q);
    end
    finish_hs();
  endtask

  task automatic test_const();
    samples = {};
    for (int k = 0; k < 256; k++) samples.push_back(1000);
    run_accum(1'b1, 256, 1'b0);
    wait_result();
    finish_hs();
  endtask

  task automatic test_negfull();
    samples = '{-32768, -32768, 32767, 32767};
    run_accum(1'b0, 4, 1'b0);
    wait_result();
    finish_hs();
  endtask

  task automatic test_hold();
    samples = '{5, -7, 9, 11};
    run_accum(1'b0, 4, 1'b0);
    wait_result();
    for (int k = 0; k < 10; k++) begin
      start2 = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (cur_m_valid !== 1'b1 || cur_s_ready !== 1'b0 || cur_mi !== last_e.i || cur_mq !== last_e.q) begin
        failures++;
        $display("FAIL hold cyc%0d: got valid=%0b ready=%0b i=%0d q=%0d required 1 0 %0d %0d",
                 k, cur_m_valid, cur_s_ready, cur_mi, cur_mq, last_e.i, last_e.q);
      end
    end
    finish_hs();
    start2 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cur_busy !== 1'b0) begin
      failures++;
      $display("FAIL start_at_handshake: got busy=%0b required 0", cur_busy);
    end
  endtask

  task automatic test_reset_mid();
    samples = '{1, 2, 3, 4};
    run_accum(1'b0, 4, 1'b0);
    samples = {};
    for (int k = 0; k < 256; k++) samples.push_back(int'($urandom_range(0, 65535)) - 32768);
    run_accum(1'b1, 100, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check_idle_zero("midreset");
    test_basic();
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) begin
      samples = {};
      for (int k = 0; k < 4; k++) samples.push_back(int'($urandom_range(0, 65535)) - 32768);
      run_accum(1'b0, 4, 1'b1);
      wait_result();
      finish_hs();
    end
    samples = {};
    for (int k = 0; k < 256; k++) samples.push_back(int'($urandom_range(0, 65535)) - 32768);
    run_accum(1'b1, 256, 1'b1);
    wait_result();
    finish_hs();
  endtask

  initial begin
    rst = 1'b1;
    start2 = 1'b0;
    start8 = 1'b0;
    s_valid = 1'b0;
    s_data = 16'd0;
    m_ready = 1'b0;
    test_reset();
    test_basic();
    test_const();
    test_negfull();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
